// File: rtl/rocc_cmd_issuer.sv
// rocc_cmd_issuer: core-side RoCC initiator. Registers host requests onto
// rocc_cmd, tracks in-flight xd writebacks per rd, buffers accelerator
// responses for the host and raises sticky protocol/timeout error flags.
module rocc_cmd_issuer #(
  parameter int XLEN            = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_funct,
  input  logic [6:0]      req_opcode,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1_idx,
  input  logic [4:0]      req_rs2_idx,
  input  logic            req_xd,
  input  logic            req_xs1,
  input  logic            req_xs2,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rocc_cmd_valid,
  input  logic            rocc_cmd_ready,
  output logic [6:0]      rocc_cmd_bits_inst_funct,
  output logic [4:0]      rocc_cmd_bits_inst_rs2,
  output logic [4:0]      rocc_cmd_bits_inst_rs1,
  output logic            rocc_cmd_bits_inst_xd,
  output logic            rocc_cmd_bits_inst_xs1,
  output logic            rocc_cmd_bits_inst_xs2,
  output logic [4:0]      rocc_cmd_bits_inst_rd,
  output logic [6:0]      rocc_cmd_bits_inst_opcode,
  output logic [XLEN-1:0] rocc_cmd_bits_rs1,
  output logic [XLEN-1:0] rocc_cmd_bits_rs2,
  input  logic            rocc_resp_valid,
  output logic            rocc_resp_ready,
  input  logic [4:0]      rocc_resp_bits_rd,
  input  logic [XLEN-1:0] rocc_resp_bits_data,
  input  logic            rocc_busy,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [OW-1:0]   outstanding,
  output logic            idle,
  output logic            err_unexpected,
  output logic            err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OW-1:0] MAX_VAL = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TO_VAL  = TW'(TIMEOUT_CYCLES);

  logic            cmd_valid_reg, cmd_valid_next;
  logic [6:0]      cmd_funct_reg, cmd_opcode_reg;
  logic [4:0]      cmd_rd_reg, cmd_rs1_idx_reg, cmd_rs2_idx_reg;
  logic            cmd_xd_reg, cmd_xs1_reg, cmd_xs2_reg;
  logic [XLEN-1:0] cmd_rs1_reg, cmd_rs2_reg;
  logic [31:0]     pending_reg, pending_next;
  logic [OW-1:0]   outstanding_reg, outstanding_next;
  logic            wb_valid_reg, wb_valid_next;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            err_unexpected_reg, err_unexpected_next;
  logic            err_timeout_reg, err_timeout_next;
  logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;

  logic hazard, full, req_fire, cmd_fire, resp_fire, wb_fire;
  logic resp_hit, sb_inc, sb_dec;

  // Hazard and full both look at pre-update state, so a response freeing rd
  // or a slot only unblocks a matching request one cycle later.
  assign hazard          = req_xd && pending_reg[req_rd];
  assign full            = req_xd && (outstanding_reg == MAX_VAL);
  assign req_ready       = (!cmd_valid_reg || rocc_cmd_ready) && !hazard && !full;
  assign rocc_resp_ready = !wb_valid_reg || wb_ready;
  assign req_fire        = req_valid && req_ready;
  assign cmd_fire        = cmd_valid_reg && rocc_cmd_ready;
  assign resp_fire       = rocc_resp_valid && rocc_resp_ready;
  assign wb_fire         = wb_valid_reg && wb_ready;
  assign resp_hit        = pending_reg[rocc_resp_bits_rd];
  assign sb_inc          = req_fire && req_xd;
  assign sb_dec          = resp_fire && resp_hit;

  // Per-register scoreboard bit: set on xd acceptance, cleared by its response.
  // An accepted xd request can never target an rd that is being cleared.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pending
      assign pending_next[gi] =
          (pending_reg[gi] && !(sb_dec && (rocc_resp_bits_rd == 5'(gi)))) ||
          (sb_inc && (req_rd == 5'(gi)));
    end
  endgenerate

  // Next-state for slot valids, outstanding count, timeout counter and flags.
  always_comb begin
    cmd_valid_next      = cmd_valid_reg;
    wb_valid_next       = wb_valid_reg;
    outstanding_next    = outstanding_reg;
    timeout_cnt_next    = timeout_cnt_reg;
    err_unexpected_next = err_unexpected_reg || (resp_fire && !resp_hit);

    if (req_fire)      cmd_valid_next = 1'b1;
    else if (cmd_fire) cmd_valid_next = 1'b0;

    if (resp_fire)     wb_valid_next = 1'b1;
    else if (wb_fire)  wb_valid_next = 1'b0;

    if (sb_inc && !sb_dec)      outstanding_next = outstanding_reg + OW'(1);
    else if (!sb_inc && sb_dec) outstanding_next = outstanding_reg - OW'(1);

    if ((outstanding_reg == '0) || resp_fire) timeout_cnt_next = '0;
    else if (timeout_cnt_reg != TO_VAL)       timeout_cnt_next = timeout_cnt_reg + TW'(1);

    err_timeout_next = err_timeout_reg || (timeout_cnt_next == TO_VAL);
  end

  // State and data registers; payloads load only on their handshakes.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid_reg      <= 1'b0;
      cmd_funct_reg      <= '0;
      cmd_opcode_reg     <= '0;
      cmd_rd_reg         <= '0;
      cmd_rs1_idx_reg    <= '0;
      cmd_rs2_idx_reg    <= '0;
      cmd_xd_reg         <= 1'b0;
      cmd_xs1_reg        <= 1'b0;
      cmd_xs2_reg        <= 1'b0;
      cmd_rs1_reg        <= '0;
      cmd_rs2_reg        <= '0;
      pending_reg        <= '0;
      outstanding_reg    <= '0;
      wb_valid_reg       <= 1'b0;
      wb_rd_reg          <= '0;
      wb_data_reg        <= '0;
      err_unexpected_reg <= 1'b0;
      err_timeout_reg    <= 1'b0;
      timeout_cnt_reg    <= '0;
    end else begin
      cmd_valid_reg      <= cmd_valid_next;
      pending_reg        <= pending_next;
      outstanding_reg    <= outstanding_next;
      wb_valid_reg       <= wb_valid_next;
      err_unexpected_reg <= err_unexpected_next;
      err_timeout_reg    <= err_timeout_next;
      timeout_cnt_reg    <= timeout_cnt_next;
      if (req_fire) begin
        cmd_funct_reg   <= req_funct;
        cmd_opcode_reg  <= req_opcode;
        cmd_rd_reg      <= req_rd;
        cmd_rs1_idx_reg <= req_rs1_idx;
        cmd_rs2_idx_reg <= req_rs2_idx;
        cmd_xd_reg      <= req_xd;
        cmd_xs1_reg     <= req_xs1;
        cmd_xs2_reg     <= req_xs2;
        cmd_rs1_reg     <= req_rs1;
        cmd_rs2_reg     <= req_rs2;
      end
      if (resp_fire) begin
        wb_rd_reg   <= rocc_resp_bits_rd;
        wb_data_reg <= rocc_resp_bits_data;
      end
    end
  end

  assign rocc_cmd_valid            = cmd_valid_reg;
  assign rocc_cmd_bits_inst_funct  = cmd_funct_reg;
  assign rocc_cmd_bits_inst_rs2    = cmd_rs2_idx_reg;
  assign rocc_cmd_bits_inst_rs1    = cmd_rs1_idx_reg;
  assign rocc_cmd_bits_inst_xd     = cmd_xd_reg;
  assign rocc_cmd_bits_inst_xs1    = cmd_xs1_reg;
  assign rocc_cmd_bits_inst_xs2    = cmd_xs2_reg;
  assign rocc_cmd_bits_inst_rd     = cmd_rd_reg;
  assign rocc_cmd_bits_inst_opcode = cmd_opcode_reg;
  assign rocc_cmd_bits_rs1         = cmd_rs1_reg;
  assign rocc_cmd_bits_rs2         = cmd_rs2_reg;
  assign wb_valid                  = wb_valid_reg;
  assign wb_rd                     = wb_rd_reg;
  assign wb_data                   = wb_data_reg;
  assign outstanding               = outstanding_reg;
  assign err_unexpected            = err_unexpected_reg;
  assign err_timeout               = err_timeout_reg;
  assign idle = !cmd_valid_reg && (outstanding_reg == '0) && !wb_valid_reg && !rocc_busy;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// tb_rocc_cmd_issuer: table-driven vectors, hand-written corner sequences and
// a randomized run against a scoreboard-level reference model.
module tb_rocc_cmd_issuer;
  localparam int XLEN = 64;
  localparam int MAXO = 4;
  localparam int TO   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid, req_ready, req_xd, req_xs1, req_xs2;
  logic [6:0] req_funct, req_opcode;
  logic [4:0] req_rd, req_rs1_idx, req_rs2_idx;
  logic [XLEN-1:0] req_rs1, req_rs2;
  logic rocc_cmd_valid, rocc_cmd_ready;
  logic [6:0] c_funct, c_opcode;
  logic [4:0] c_rs2i, c_rs1i, c_rd;
  logic c_xd, c_xs1, c_xs2;
  logic [XLEN-1:0] c_rs1, c_rs2;
  logic rocc_resp_valid, rocc_resp_ready, rocc_busy;
  logic [4:0] rocc_resp_bits_rd;
  logic [XLEN-1:0] rocc_resp_bits_data;
  logic wb_valid, wb_ready;
  logic [4:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [2:0] outstanding;
  logic idle, err_unexpected, err_timeout;

  int errors = 0;
  int checks = 0;

  rocc_cmd_issuer #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_opcode(req_opcode),
    .req_rd(req_rd), .req_rs1_idx(req_rs1_idx), .req_rs2_idx(req_rs2_idx),
    .req_xd(req_xd), .req_xs1(req_xs1), .req_xs2(req_xs2),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
    .rocc_cmd_bits_inst_funct(c_funct), .rocc_cmd_bits_inst_rs2(c_rs2i),
    .rocc_cmd_bits_inst_rs1(c_rs1i), .rocc_cmd_bits_inst_xd(c_xd),
    .rocc_cmd_bits_inst_xs1(c_xs1), .rocc_cmd_bits_inst_xs2(c_xs2),
    .rocc_cmd_bits_inst_rd(c_rd), .rocc_cmd_bits_inst_opcode(c_opcode),
    .rocc_cmd_bits_rs1(c_rs1), .rocc_cmd_bits_rs2(c_rs2),
    .rocc_resp_valid(rocc_resp_valid), .rocc_resp_ready(rocc_resp_ready),
    .rocc_resp_bits_rd(rocc_resp_bits_rd), .rocc_resp_bits_data(rocc_resp_bits_data),
    .rocc_busy(rocc_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .outstanding(outstanding), .idle(idle),
    .err_unexpected(err_unexpected), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rv; logic xd; logic [4:0] rd; logic [63:0] rs1; logic cr;
    logic sv; logic [4:0] srd; logic [63:0] sdata; logic wr;
    logic e_rr; logic e_sr; logic e_cv; logic [4:0] e_crd; logic [63:0] e_crs1;
    logic e_wv; logic [4:0] e_wrd; logic [63:0] e_wdata; logic [2:0] e_out; logic e_idle;
  } vec_t;

  vec_t tbl [14];

  // reference model state
  bit          m_pend [32];
  bit          m_cv, m_wv, m_eu, m_et;
  logic [4:0]  m_crd, m_wrd;
  logic [6:0]  m_cfunct;
  logic        m_cxd;
  logic [63:0] m_crs1, m_crs2, m_wdata;
  int          m_tcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic half();
    @(negedge clock);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    req_valid = 0; req_xd = 0; req_rd = 0; req_rs1 = 0; req_rs2 = 0;
    req_funct = 0; req_opcode = 7'h0b; req_rs1_idx = 5'd1; req_rs2_idx = 5'd2;
    req_xs1 = 1; req_xs2 = 1;
    rocc_cmd_ready = 1; rocc_resp_valid = 0; rocc_resp_bits_rd = 0;
    rocc_resp_bits_data = 0; wb_ready = 1; rocc_busy = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clr_in();
    adv();
    adv();
    reset = 0;
  endtask

  task automatic put_req(input logic xd, input logic [4:0] rd, input logic [63:0] rs1);
    req_valid = 1; req_xd = xd; req_rd = rd; req_rs1 = rs1; req_rs2 = rs1 + 64'd1;
  endtask

  function automatic int popc();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  initial begin
    // single accumulate, then backpressure with a queued second request
    tbl[0]  = '{1'b1,1'b1,5'd5,64'h3, 1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b0,5'd0,64'h0,   1'b0,5'd0,64'h0, 3'd0,1'b1};
    tbl[1]  = '{1'b0,1'b0,5'd0,64'h0, 1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b1,5'd5,64'h3,   1'b0,5'd0,64'h0, 3'd1,1'b0};
    tbl[2]  = '{1'b0,1'b0,5'd0,64'h0, 1'b1, 1'b1,5'd5,64'h7, 1'b1,  1'b1,1'b1,1'b0,5'd0,64'h0,   1'b0,5'd0,64'h0, 3'd1,1'b0};
    tbl[3]  = '{1'b0,1'b0,5'd0,64'h0, 1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b0,5'd0,64'h0,   1'b1,5'd5,64'h7, 3'd0,1'b0};
    tbl[4]  = '{1'b0,1'b0,5'd0,64'h0, 1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b0,5'd0,64'h0,   1'b0,5'd0,64'h0, 3'd0,1'b1};
    tbl[5]  = '{1'b1,1'b0,5'd1,64'h11,1'b0, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b0,5'd0,64'h0,   1'b0,5'd0,64'h0, 3'd0,1'b1};
    for (int i = 6; i < 11; i++)
      tbl[i] = '{1'b1,1'b0,5'd2,64'h33,1'b0, 1'b0,5'd0,64'h0, 1'b1,  1'b0,1'b1,1'b1,5'd1,64'h11,  1'b0,5'd0,64'h0, 3'd0,1'b0};
    tbl[11] = '{1'b1,1'b0,5'd2,64'h33,1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b1,5'd1,64'h11,  1'b0,5'd0,64'h0, 3'd0,1'b0};
    tbl[12] = '{1'b0,1'b0,5'd0,64'h0, 1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b1,5'd2,64'h33,  1'b0,5'd0,64'h0, 3'd0,1'b0};
    tbl[13] = '{1'b0,1'b0,5'd0,64'h0, 1'b1, 1'b0,5'd0,64'h0, 1'b1,  1'b1,1'b1,1'b0,5'd0,64'h0,   1'b0,5'd0,64'h0, 3'd0,1'b1};

    // ---------------- reset state
    do_reset();
    half();
    chk("rst_cmd_valid", rocc_cmd_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_unexp", err_unexpected, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_ready", rocc_resp_ready, 1);
    chk("rst_cmd_rs1", c_rs1, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_idle", idle, 1);
    $display("reset: checked reset state");
    adv();

    // ---------------- table vectors
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].rv; req_xd = tbl[i].xd; req_rd = tbl[i].rd;
      req_rs1 = tbl[i].rs1; req_rs2 = tbl[i].rs1 + 64'd1;
      rocc_cmd_ready = tbl[i].cr; rocc_resp_valid = tbl[i].sv;
      rocc_resp_bits_rd = tbl[i].srd; rocc_resp_bits_data = tbl[i].sdata;
      wb_ready = tbl[i].wr;
      half();
      chk($sformatf("vec%0d_req_ready", i), req_ready, tbl[i].e_rr);
      chk($sformatf("vec%0d_resp_ready", i), rocc_resp_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_cmd_valid", i), rocc_cmd_valid, tbl[i].e_cv);
      if (tbl[i].e_cv) begin
        chk($sformatf("vec%0d_cmd_rd", i), c_rd, tbl[i].e_crd);
        chk($sformatf("vec%0d_cmd_rs1", i), c_rs1, tbl[i].e_crs1);
        chk($sformatf("vec%0d_cmd_rs2", i), c_rs2, tbl[i].e_crs1 + 64'd1);
      end
      chk($sformatf("vec%0d_wb_valid", i), wb_valid, tbl[i].e_wv);
      if (tbl[i].e_wv) begin
        chk($sformatf("vec%0d_wb_rd", i), wb_rd, tbl[i].e_wrd);
        chk($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].e_wdata);
      end
      chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("vec%0d_idle", i), idle, tbl[i].e_idle);
      $display("vec %0d: req_v=%0d cmd_rdy=%0d resp_v=%0d -> req_rdy=%0d cmd_v=%0d wb_v=%0d out=%0d",
               i, req_valid, rocc_cmd_ready, rocc_resp_valid, req_ready, rocc_cmd_valid, wb_valid, outstanding);
      adv();
    end
    clr_in();

    // ---------------- WAW hazard on rd=7
    do_reset();
    put_req(1, 5'd7, 64'h70);
    half(); chk("waw_first_ready", req_ready, 1); adv();
    put_req(1, 5'd7, 64'h71);
    for (int k = 0; k < 3; k++) begin
      half(); chk("waw_stall", req_ready, 0); adv();
    end
    rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd7; rocc_resp_bits_data = 64'h77;
    half(); chk("waw_stall_on_resp", req_ready, 0); adv();
    rocc_resp_valid = 0;
    half();
    chk("waw_ready_after", req_ready, 1);
    chk("waw_wb_data", wb_data, 64'h77);
    chk("waw_out_zero", outstanding, 0);
    adv();
    clr_in();
    half();
    chk("waw_cmd_rs1", c_rs1, 64'h71);
    chk("waw_out_one", outstanding, 1);
    $display("waw: second rd=7 accepted after response");
    adv();

    // ---------------- outstanding limit
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      put_req(1, 5'(r), 64'(r));
      half(); chk("lim_accept", req_ready, 1); adv();
    end
    put_req(1, 5'd5, 64'h5);
    half();
    chk("lim_out4", outstanding, 4);
    chk("lim_full_stall", req_ready, 0);
    req_xd = 0;
    #1;
    chk("lim_xd0_ready", req_ready, 1);
    adv();
    clr_in();
    half();
    chk("lim_xd0_issued", c_xd, 0);
    chk("lim_out_still4", outstanding, 4);
    $display("limit: 5th xd stalled, xd=0 accepted");
    adv();

    // ---------------- simultaneous response and request
    do_reset();
    put_req(1, 5'd2, 64'h20);
    half(); adv();
    put_req(1, 5'd9, 64'h90);
    rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd2; rocc_resp_bits_data = 64'h5;
    wb_ready = 0;
    half();
    chk("sim_req_ready", req_ready, 1);
    chk("sim_resp_ready", rocc_resp_ready, 1);
    adv();
    req_valid = 0; rocc_resp_bits_rd = 5'd9;
    half();
    chk("sim_out_unchanged", outstanding, 1);
    chk("sim_cmd_rd", c_rd, 9);
    chk("sim_wb_valid", wb_valid, 1);
    chk("sim_resp_throttled", rocc_resp_ready, 0);
    adv();
    half();
    chk("sim_no_fire", outstanding, 1);
    $display("simultaneous: outstanding held, resp throttled by wb");
    adv();
    clr_in();

    // ---------------- unexpected response
    do_reset();
    rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd12; rocc_resp_bits_data = 64'habc;
    half(); adv();
    clr_in();
    half();
    chk("unexp_flag", err_unexpected, 1);
    chk("unexp_wb_valid", wb_valid, 1);
    chk("unexp_wb_rd", wb_rd, 12);
    chk("unexp_wb_data", wb_data, 64'habc);
    chk("unexp_out", outstanding, 0);
    $display("unexpected: rd=12 forwarded, flag set");
    adv();

    // ---------------- timeout
    do_reset();
    put_req(1, 5'd3, 64'h3);
    half(); adv();
    clr_in();
    chk("to_out_one", outstanding, 1);
    chk("to_not_yet", err_timeout, 0);
    begin
      int n = 0;
      while (!err_timeout && n < 100) begin
        adv();
        n++;
      end
      chk("to_cycles", 64'(n), 64'(TO));
      $display("timeout: err_timeout after %0d cycles", n);
    end

    // ---------------- reset mid-flight
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      put_req(1, 5'(r), 64'(r));
      half(); adv();
    end
    put_req(0, 5'd0, 64'h55);
    rocc_cmd_ready = 0;
    half(); adv();
    req_valid = 0;
    half();
    chk("mid_out3", outstanding, 3);
    chk("mid_cmd_valid", rocc_cmd_valid, 1);
    reset = 1;
    adv();
    reset = 0;
    half();
    chk("mid_rst_cmd_valid", rocc_cmd_valid, 0);
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_cmd_rs1", c_rs1, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_resp_ready", rocc_resp_ready, 1);
    chk("mid_rst_idle", idle, 1);
    adv();
    rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd2;
    half(); adv();
    clr_in();
    half();
    chk("mid_late_resp", err_unexpected, 1);
    $display("reset mid-flight: state cleared, late response flagged");
    adv();

    // ---------------- randomized run against reference model
    do_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_cv = 0; m_wv = 0; m_eu = 0; m_et = 0; m_tcnt = 0;
    m_crd = 0; m_wrd = 0; m_cfunct = 0; m_cxd = 0; m_crs1 = 0; m_crs2 = 0; m_wdata = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int q [$];
      int outst;
      bit e_rr, e_sr, rf, cf, sf, wf;
      req_valid = ($urandom_range(9) < 6);
      req_xd = $urandom_range(1);
      req_rd = 5'($urandom_range(7));
      req_funct = 7'($urandom);
      req_rs1 = {$urandom, $urandom};
      req_rs2 = {$urandom, $urandom};
      rocc_cmd_ready = ($urandom_range(9) < 7);
      wb_ready = ($urandom_range(9) < 7);
      rocc_busy = ($urandom_range(9) < 2);
      for (int i = 0; i < 32; i++) if (m_pend[i]) q.push_back(i);
      rocc_resp_valid = ($urandom_range(9) < 4);
      if (q.size() > 0 && $urandom_range(9) < 9)
        rocc_resp_bits_rd = 5'(q[$urandom_range(q.size() - 1)]);
      else
        rocc_resp_bits_rd = 5'($urandom_range(31));
      rocc_resp_bits_data = {$urandom, $urandom};
      half();

      outst = popc();
      e_rr = (!m_cv || rocc_cmd_ready) && !(req_xd && m_pend[req_rd]) && !(req_xd && outst == MAXO);
      e_sr = !m_wv || wb_ready;
      chk("rnd_req_ready", req_ready, e_rr);
      chk("rnd_resp_ready", rocc_resp_ready, e_sr);
      chk("rnd_cmd_valid", rocc_cmd_valid, m_cv);
      if (m_cv) begin
        chk("rnd_cmd_rd", c_rd, m_crd);
        chk("rnd_cmd_funct", c_funct, m_cfunct);
        chk("rnd_cmd_xd", c_xd, m_cxd);
        chk("rnd_cmd_rs1", c_rs1, m_crs1);
        chk("rnd_cmd_rs2", c_rs2, m_crs2);
      end
      chk("rnd_wb_valid", wb_valid, m_wv);
      if (m_wv) begin
        chk("rnd_wb_rd", wb_rd, m_wrd);
        chk("rnd_wb_data", wb_data, m_wdata);
      end
      chk("rnd_outstanding", outstanding, 64'(outst));
      chk("rnd_err_unexp", err_unexpected, m_eu);
      chk("rnd_err_timeout", err_timeout, m_et);
      chk("rnd_idle", idle, !m_cv && outst == 0 && !m_wv && !rocc_busy);

      rf = req_valid && e_rr;
      cf = m_cv && rocc_cmd_ready;
      sf = rocc_resp_valid && e_sr;
      wf = m_wv && wb_ready;
      if (outst == 0 || sf) m_tcnt = 0;
      else if (m_tcnt < TO) m_tcnt++;
      if (m_tcnt == TO) m_et = 1;
      if (sf) begin
        if (!m_pend[rocc_resp_bits_rd]) m_eu = 1;
        m_pend[rocc_resp_bits_rd] = 0;
        m_wv = 1; m_wrd = rocc_resp_bits_rd; m_wdata = rocc_resp_bits_data;
      end else if (wf) m_wv = 0;
      if (rf) begin
        if (req_xd) m_pend[req_rd] = 1;
        m_cv = 1; m_crd = req_rd; m_cfunct = req_funct; m_cxd = req_xd;
        m_crs1 = req_rs1; m_crs2 = req_rs2;
        $display("rnd %0d: req rd=%0d xd=%0d accepted, outstanding=%0d", cyc, req_rd, req_xd, popc());
      end else if (cf) m_cv = 0;
      adv();
    end
    clr_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
